pool_window_streamer: RTL and testbench
=======================================

Name: pool_window_streamer

Overview:
- Producer end of the serial pixel interface consumed by the FP32 average-pool unit.
- The unit takes one FP32 pixel per clock while `start` is high and averages each group of 4.
- This block buffers a full feature map and streams every non-overlapping 2x2 window in raster order, one pixel per cycle, with `start` framing each window.
- Sits between the feature-map writer (conv/activation output) and the pooling unit.

Parameters:
- IMG_W, 4, feature-map width in pixels; must be even and >= 2.
- IMG_H, 4, feature-map height in pixels; must be even and >= 2.
- GAP_CYCLES, 1, idle cycles with `start` = 0 between consecutive windows; 0 is legal.
- DATA_W, 32, pixel width (IEEE-754 single).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  clog2(IMG_W*IMG_H)  raster address (row*IMG_W+col).
- wr_data  in  DATA_W  pixel to store.
- go  in  1  single-cycle request to stream the whole map.
- In1  out  DATA_W  streamed pixel to the pooling unit.
- start  out  1  high while In1 carries a valid window pixel.
- win_idx  out  clog2(NUM_WIN)  index of the window on In1; NUM_WIN = (IMG_W/2)*(IMG_H/2).
- busy  out  1  high from the accepted go until done.
- done  out  1  one-cycle pulse after the last pixel of the last window.

Behaviour:
- Reset: In1=0, start=0, win_idx=0, busy=0, done=0, FSM=IDLE, all counters 0. Buffer contents are not cleared.
- Buffer: IMG_W*IMG_H x DATA_W array with an asynchronous read, registered into In1.
  - Writes are accepted only in IDLE and DONE.
  - wr_en in STREAM or GAP is ignored.
  - wr_addr >= IMG_W*IMG_H is ignored.
- FSM states: IDLE, STREAM, GAP, DONE.
  - IDLE: go=1 -> STREAM at the next edge; busy=1 from that edge. go is ignored while busy.
  - STREAM: pixel counter k=0..3. Window (r,c) pixel k address = (2r+k[1])*IMG_W + 2c + k[0], giving order top-left, top-right, bottom-left, bottom-right.
    - In1/start/win_idx are registered: pixel k is on In1 with start=1 in the cycle after the edge on which the FSM issued it.
    - After k=3: if more windows remain -> GAP (GAP_CYCLES>0) or straight to the next window's STREAM (GAP_CYCLES=0); otherwise -> DONE.
  - Window order: c increments 0..IMG_W/2-1, wrapping to 0 and incrementing r; win_idx = r*(IMG_W/2)+c.
  - GAP: start=0, In1 holds its last value, counts GAP_CYCLES, then -> STREAM.
  - DONE: done=1 for exactly one cycle, coinciding with the first cycle start=0 after the final pixel; busy=0 in that cycle. Then -> IDLE.
  - go arriving in the DONE cycle is ignored.
- Latency:
  - go sampled at edge N -> first pixel valid in the cycle after edge N+1.
  - Total stream = 4*NUM_WIN + GAP_CYCLES*(NUM_WIN-1) cycles.
- GAP_CYCLES=0: start stays high continuously for 4*NUM_WIN cycles.
- Simultaneous wr_en and go in IDLE: the write commits at the same edge and is visible to the stream.
- rst mid-stream: immediate return to IDLE with outputs at reset values; no done pulse; buffer retained, so a new go restarts from window 0.
- Elaboration error if IMG_W or IMG_H is odd or < 2.

Decomposition:
- Package pool_pkg: DATA_W, the FSM state enum, and the fp32 localparams used by benches (FP_ONE = 32'h3F800000).
- One natural sub-module, `fmap_buffer`: the array with write port and async read.
- FSM, window/pixel counters and the address generator stay in pool_window_streamer.

Test Plan:
- 4x4 map loaded with 1.0..16.0 raster, GAP=1, go -> In1 sequence 3F800000, 40000000, 40A00000, 40C00000 (win 0), 1 cycle start=0, then 40400000, 40800000, 40E00000, 41000000 (win 1); done pulses 19 cycles after the first pixel.
- Same map, last window -> 41300000, 41400000, 41700000, 41800000 with win_idx=3, then done=1 for one cycle and busy=0.
- GAP_CYCLES=0 -> start high for 16 consecutive cycles; win_idx changes every 4 cycles.
- wr_en to addr 0 with 0 during STREAM -> ignored; a second go afterwards still streams 3F800000 first.
- rst asserted on the 6th streamed pixel -> next cycle start=0, busy=0, In1=0, no done; a new go streams window 0 correctly.
- go pulsed while busy, and go with a same-cycle write to addr 5 = 41200000 in IDLE -> the extra go is ignored; win 0 pixel 3 shows 41200000.

Source files
------------

// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the average-pool window streamer slice.
//   DATA_W   : default pixel width (IEEE-754 single precision)
//   state_e  : streamer FSM states
//   FP_ONE.. : fp32 constants handy for benches driving/checking pixel data
// -----------------------------------------------------------------------------
package pool_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fmap_buffer.sv
// -----------------------------------------------------------------------------
// fmap_buffer
// Feature-map storage: DEPTH x DATA_W array, one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk   : system clock, rising edge
//   we    : write enable (already qualified by the caller)
//   waddr : write address, must be < DEPTH when we=1
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
// -----------------------------------------------------------------------------
module fmap_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_window_streamer.sv
// -----------------------------------------------------------------------------
// pool_window_streamer
// Buffers an IMG_W x IMG_H feature map and streams every non-overlapping 2x2
// window in raster order (TL, TR, BL, BR), one pixel per clock, to the fp32
// average-pool unit. `start` frames each window; GAP_CYCLES idle cycles are
// inserted between windows.
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   wr_en/addr/data : buffer write port, accepted only while idle or done
//   go              : single-cycle request to stream the whole map
//   In1             : streamed pixel (registered)
//   start           : high while In1 carries a valid window pixel
//   win_idx         : index of the window currently on In1
//   busy            : high from the accepted go until the done cycle
//   done            : one-cycle pulse after the last pixel of the last window
// -----------------------------------------------------------------------------
module pool_window_streamer #(
    parameter int IMG_W      = 4,
    parameter int IMG_H      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int DATA_W     = pool_pkg::DATA_W
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_en,
    input  logic [$clog2(IMG_W*IMG_H)-1:0]           wr_addr,
    input  logic [DATA_W-1:0]                        wr_data,
    input  logic                                     go,
    output logic [DATA_W-1:0]                        In1,
    output logic                                     start,
    output logic [(((IMG_W/2)*(IMG_H/2)) > 1 ?
                   $clog2((IMG_W/2)*(IMG_H/2)) : 1)-1:0] win_idx,
    output logic                                     busy,
    output logic                                     done
);

    import pool_pkg::*;

    localparam int NPIX    = IMG_W * IMG_H;
    localparam int ADDR_W  = $clog2(NPIX);
    localparam int COLS    = IMG_W / 2;
    localparam int ROWS    = IMG_H / 2;
    localparam int NUM_WIN = COLS * ROWS;
    localparam int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NUM_WIN - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if ((IMG_W < 2) || ((IMG_W % 2) != 0) || (IMG_H < 2) || ((IMG_H % 2) != 0)
        || (GAP_CYCLES < 0)) begin : g_cfg_err
        $error("pool_window_streamer: IMG_W/IMG_H must be even and >= 2, GAP_CYCLES >= 0");
    end

    state_e             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               drain_q, drain_d;
    logic [DATA_W-1:0]  in1_q, in1_d;
    logic               start_q, start_d;
    logic [WIN_W-1:0]   win_idx_q, win_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               wr_ok;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;

    assign wr_ok = wr_en
                && ((state_q == ST_IDLE) || (state_q == ST_DONE))
                && ({1'b0, wr_addr} < (ADDR_W+1)'(NPIX));

    // Pixel k of window (row, col): row offset from k[1], column offset from k[0].
    assign rd_addr = ADDR_W'((2 * 32'(row_q) + 32'(k_q[1])) * IMG_W
                             + 2 * 32'(col_q) + 32'(k_q[0]));

    fmap_buffer #(
        .DEPTH (NPIX),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_buf (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wr_addr),
        .wdata(wr_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        gap_d     = gap_q;
        drain_d   = drain_q;
        in1_d     = in1_q;
        start_d   = 1'b0;
        win_idx_d = win_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_STREAM;
                    busy_d  = 1'b1;
                    k_d     = '0;
                    col_d   = '0;
                    row_d   = '0;
                    win_d   = '0;
                    drain_d = 1'b0;
                end
            end

            ST_STREAM: begin
                // The drain cycle lets the final pixel sit on In1 for its own
                // cycle, so DONE lines up with the first start=0 cycle.
                if (drain_q) begin
                    state_d = ST_DONE;
                    drain_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    in1_d     = rd_data;
                    start_d   = 1'b1;
                    win_idx_d = win_q;
                    k_d       = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        if (win_q == WIN_LAST) begin
                            drain_d = 1'b1;
                            col_d   = '0;
                            row_d   = '0;
                            win_d   = '0;
                        end else begin
                            win_d = win_q + 1'b1;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_q + 1'b1;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                            if (GAP_CYCLES > 0) begin
                                state_d = ST_GAP;
                                gap_d   = '0;
                            end
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_STREAM;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            gap_q     <= '0;
            drain_q   <= 1'b0;
            in1_q     <= '0;
            start_q   <= 1'b0;
            win_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            gap_q     <= gap_d;
            drain_q   <= drain_d;
            in1_q     <= in1_d;
            start_q   <= start_d;
            win_idx_q <= win_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign In1     = in1_q;
    assign start   = start_q;
    assign win_idx = win_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pool_window_streamer.sv
// -----------------------------------------------------------------------------
// tb_pool_window_streamer
// Drives two streamers (GAP_CYCLES=1 and GAP_CYCLES=0) from the same write/go
// stimulus and checks their outputs against a fixed vector table and a
// stream-order reference model derived from window/pixel arithmetic.
// -----------------------------------------------------------------------------
module tb_pool_window_streamer;

    import pool_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NW = (W / 2) * (H / 2);
    localparam int NCAP = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        go;

    logic [31:0] in1_a, in1_b;
    logic        start_a, start_b;
    logic [1:0]  win_a, win_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    always #5 clk = ~clk;

    pool_window_streamer #(
        .IMG_W(W), .IMG_H(H), .GAP_CYCLES(1), .DATA_W(32)
    ) dut_g1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .In1(in1_a), .start(start_a), .win_idx(win_a), .busy(busy_a), .done(done_a)
    );

    pool_window_streamer #(
        .IMG_W(W), .IMG_H(H), .GAP_CYCLES(0), .DATA_W(32)
    ) dut_g0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .In1(in1_b), .start(start_b), .win_idx(win_b), .busy(busy_b), .done(done_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m  [16];
    logic [31:0] fp_lut [16];

    logic [31:0] c_in1   [2][NCAP];
    logic        c_start [2][NCAP];
    logic [1:0]  c_win   [2][NCAP];
    logic        c_busy  [2][NCAP];
    logic        c_done  [2][NCAP];

    typedef struct {
        int          cyc;
        logic [31:0] in1;
        bit          chk_in1;
        bit          start;
        logic [1:0]  win;
        bit          done;
        bit          busy;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // Records n cycles of both DUTs, cycle 0 being the first edge after go.
    // go is raised during cycles ga and gb (use -1 for none).
    task automatic capture(input int n, input int ga, input int gb);
        for (int i = 0; i < n; i++) begin
            tick();
            c_in1[0][i] = in1_a;  c_start[0][i] = start_a; c_win[0][i] = win_a;
            c_busy[0][i] = busy_a; c_done[0][i] = done_a;
            c_in1[1][i] = in1_b;  c_start[1][i] = start_b; c_win[1][i] = win_b;
            c_busy[1][i] = busy_b; c_done[1][i] = done_b;
            go = (i == ga) || (i == gb);
        end
        go = 1'b0;
    endtask

    // Reference: cycle i belongs to window i/(4+gap); offsets 0..3 are pixels,
    // the rest are gap cycles holding the window's last pixel.
    task automatic check_model(input int d, input int gap, input int n, input string tag);
        int per, total, w, p, r, c, a;
        per   = 4 + gap;
        total = 4 * NW + gap * (NW - 1);
        for (int i = 0; i < n; i++) begin
            w = i / per;
            p = i % per;
            if (i < total) begin
                r = w / (W / 2);
                c = w % (W / 2);
                if (p < 4) begin
                    a = (2 * r + p / 2) * W + 2 * c + p % 2;
                    check($sformatf("%s c%0d in1", tag, i), c_in1[d][i], mem_m[a]);
                    check($sformatf("%s c%0d start", tag, i), 32'(c_start[d][i]), 1);
                    check($sformatf("%s c%0d win", tag, i), 32'(c_win[d][i]), w);
                end else begin
                    a = (2 * r + 1) * W + 2 * c + 1;
                    check($sformatf("%s c%0d gap_hold", tag, i), c_in1[d][i], mem_m[a]);
                    check($sformatf("%s c%0d start", tag, i), 32'(c_start[d][i]), 0);
                end
                check($sformatf("%s c%0d busy", tag, i), 32'(c_busy[d][i]), 1);
                check($sformatf("%s c%0d done", tag, i), 32'(c_done[d][i]), 0);
            end else begin
                check($sformatf("%s c%0d start", tag, i), 32'(c_start[d][i]), 0);
                check($sformatf("%s c%0d busy", tag, i), 32'(c_busy[d][i]), 0);
                check($sformatf("%s c%0d done", tag, i), 32'(c_done[d][i]), (i == total) ? 1 : 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fp_lut[0]  = 32'h3F800000; fp_lut[1]  = 32'h40000000;
        fp_lut[2]  = 32'h40400000; fp_lut[3]  = 32'h40800000;
        fp_lut[4]  = 32'h40A00000; fp_lut[5]  = 32'h40C00000;
        fp_lut[6]  = 32'h40E00000; fp_lut[7]  = 32'h41000000;
        fp_lut[8]  = 32'h41100000; fp_lut[9]  = 32'h41200000;
        fp_lut[10] = 32'h41300000; fp_lut[11] = 32'h41400000;
        fp_lut[12] = 32'h41500000; fp_lut[13] = 32'h41600000;
        fp_lut[14] = 32'h41700000; fp_lut[15] = 32'h41800000;

        // Expected GAP_CYCLES=1 stream for the 1.0..16.0 map.
        tbl[0]  = '{0,  32'h3F800000, 1, 1, 2'd0, 0, 1};
        tbl[1]  = '{1,  32'h40000000, 1, 1, 2'd0, 0, 1};
        tbl[2]  = '{2,  32'h40A00000, 1, 1, 2'd0, 0, 1};
        tbl[3]  = '{3,  32'h40C00000, 1, 1, 2'd0, 0, 1};
        tbl[4]  = '{4,  32'h40C00000, 1, 0, 2'd0, 0, 1};
        tbl[5]  = '{5,  32'h40400000, 1, 1, 2'd1, 0, 1};
        tbl[6]  = '{6,  32'h40800000, 1, 1, 2'd1, 0, 1};
        tbl[7]  = '{7,  32'h40E00000, 1, 1, 2'd1, 0, 1};
        tbl[8]  = '{8,  32'h41000000, 1, 1, 2'd1, 0, 1};
        tbl[9]  = '{9,  32'h41000000, 1, 0, 2'd1, 0, 1};
        tbl[10] = '{10, 32'h41100000, 1, 1, 2'd2, 0, 1};
        tbl[11] = '{11, 32'h41200000, 1, 1, 2'd2, 0, 1};
        tbl[12] = '{12, 32'h41500000, 1, 1, 2'd2, 0, 1};
        tbl[13] = '{13, 32'h41600000, 1, 1, 2'd2, 0, 1};
        tbl[14] = '{14, 32'h41600000, 1, 0, 2'd2, 0, 1};
        tbl[15] = '{15, 32'h41300000, 1, 1, 2'd3, 0, 1};
        tbl[16] = '{16, 32'h41400000, 1, 1, 2'd3, 0, 1};
        tbl[17] = '{17, 32'h41700000, 1, 1, 2'd3, 0, 1};
        tbl[18] = '{18, 32'h41800000, 1, 1, 2'd3, 0, 1};
        tbl[19] = '{19, 32'h00000000, 0, 0, 2'd0, 1, 0};
        tbl[20] = '{20, 32'h00000000, 0, 0, 2'd0, 0, 0};

        rst = 1'b1; wr_en = 1'b0; go = 1'b0; wr_addr = '0; wr_data = '0;
        tick();
        tick();

        // Reset state
        check("rst in1_g1",  in1_a, 0);          check("rst in1_g0",  in1_b, 0);
        check("rst start_g1", 32'(start_a), 0);  check("rst start_g0", 32'(start_b), 0);
        check("rst win_g1",  32'(win_a), 0);     check("rst win_g0",  32'(win_b), 0);
        check("rst busy_g1", 32'(busy_a), 0);    check("rst busy_g0", 32'(busy_b), 0);
        check("rst done_g1", 32'(done_a), 0);    check("rst done_g0", 32'(done_b), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            write_px(i, fp_lut[i]);
            mem_m[i] = fp_lut[i];
        end

        // Ordered map, fixed vectors for GAP=1, model for GAP=0
        pulse_go();
        capture(22, -1, -1);
        for (int v = 0; v < 21; v++) begin
            if (tbl[v].chk_in1)
                check($sformatf("tbl c%0d in1", tbl[v].cyc), c_in1[0][tbl[v].cyc], tbl[v].in1);
            check($sformatf("tbl c%0d start", tbl[v].cyc), 32'(c_start[0][tbl[v].cyc]), 32'(tbl[v].start));
            if (tbl[v].start)
                check($sformatf("tbl c%0d win", tbl[v].cyc), 32'(c_win[0][tbl[v].cyc]), 32'(tbl[v].win));
            check($sformatf("tbl c%0d done", tbl[v].cyc), 32'(c_done[0][tbl[v].cyc]), 32'(tbl[v].done));
            check($sformatf("tbl c%0d busy", tbl[v].cyc), 32'(c_busy[0][tbl[v].cyc]), 32'(tbl[v].busy));
        end
        check_model(1, 0, 18, "g0_ordered");

        // Writes during the stream must be dropped
        pulse_go();
        tick();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0;
        tick(); tick(); tick();
        wr_en = 1'b0;
        repeat (20) tick();
        pulse_go();
        capture(22, -1, -1);
        check("wr_in_stream first_px", c_in1[0][0], FP_ONE);
        check_model(0, 1, 22, "g1_wrblock");
        check_model(1, 0, 18, "g0_wrblock");

        // Reset while the 6th pixel is on the output
        pulse_go();
        repeat (6) tick();
        rst = 1'b1;
        tick();
        check("midrst start_g1", 32'(start_a), 0); check("midrst busy_g1", 32'(busy_a), 0);
        check("midrst in1_g1", in1_a, 0);          check("midrst done_g1", 32'(done_a), 0);
        check("midrst start_g0", 32'(start_b), 0); check("midrst busy_g0", 32'(busy_b), 0);
        check("midrst in1_g0", in1_b, 0);          check("midrst done_g0", 32'(done_b), 0);
        rst = 1'b0;
        capture(20, -1, -1);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("postrst c%0d done_g1", i), 32'(c_done[0][i]), 0);
            check($sformatf("postrst c%0d busy_g0", i), 32'(c_busy[1][i]), 0);
        end
        pulse_go();
        capture(22, -1, -1);
        check_model(0, 1, 22, "g1_restart");
        check_model(1, 0, 18, "g0_restart");

        // go with a same-cycle write, then go pulses while busy / in DONE (g0)
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h41200000; go = 1'b1;
        tick();
        wr_en = 1'b0; go = 1'b0;
        mem_m[5] = 32'h41200000;
        capture(22, 2, 16);
        check("wr_with_go w0p3", c_in1[0][3], 32'h41200000);
        check_model(0, 1, 22, "g1_gobusy");
        check_model(1, 0, 18, "g0_gobusy");

        // Random maps
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    logic [31:0] d;
                    d = $urandom;
                    write_px(i, d);
                    mem_m[i] = d;
                end
            end
            pulse_go();
            capture(22, -1, -1);
            check_model(0, 1, 22, $sformatf("g1_rand%0d", t));
            check_model(1, 0, 18, $sformatf("g0_rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
